oc8051_ice_xmem_arb: RTL and testbench

//  Arbitrates one single-port external data RAM between the oc8051 core XDATA port and the

---
 rtl/oc8051_ice_xmem_arb.sv | 119 +++++++++++
 tb/tb_oc8051_ice_xmem_arb.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oc8051_ice_xmem_arb.sv
// External data RAM arbiter for the oc8051 iCE build: shares one single-port RAM between the
// core XDATA port and the debug/loader port with round-robin, debug lock and fixed-latency access.
module oc8051_ice_xmem_arb #(
  parameter int AW      = 16,
  parameter int MEM_LAT = 1,
  parameter int CW      = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_core_req,
  input  logic          i_core_we,
  input  logic [AW-1:0] i_core_addr,
  input  logic [7:0]    i_core_wdat,
  output logic          o_core_ack,
  output logic [7:0]    o_core_rdat,
  input  logic          i_dbg_req,
  input  logic          i_dbg_we,
  input  logic [AW-1:0] i_dbg_addr,
  input  logic [7:0]    i_dbg_wdat,
  output logic          o_dbg_ack,
  output logic [7:0]    o_dbg_rdat,
  input  logic          i_dbg_lock,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [7:0]    o_mem_wdat,
  input  logic [7:0]    i_mem_rdat,
  output logic          o_busy,
  output logic [CW-1:0] o_core_wait
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

  state_t     state, state_nxt;
  logic       owner_dbg;
  logic       last_dbg;
  logic       we_q;
  logic [1:0] lat_cnt;
  logic       grant_core, grant_dbg, lat_done, core_served;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Arbitration: lock gives debug strict priority, otherwise a tie goes to whoever lost last.
  always_comb begin
    grant_core = 1'b0;
    grant_dbg  = 1'b0;
    if (state == IDLE) begin
      if (i_dbg_lock) begin
        grant_dbg = i_dbg_req;
      end else if (i_core_req && i_dbg_req) begin
        grant_core = last_dbg;
        grant_dbg  = !last_dbg;
      end else begin
        grant_core = i_core_req;
        grant_dbg  = i_dbg_req;
      end
    end
  end

  assign lat_done    = (lat_cnt == LAT_LAST);
  assign core_served = (state == ACCESS || state == ACK) && !owner_dbg;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_core || grant_dbg) state_nxt = ACCESS;
      ACCESS:  if (lat_done) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_mem_en   = (state == ACCESS);
    o_mem_we   = (state == ACCESS) && we_q;
    o_core_ack = (state == ACK) && !owner_dbg;
    o_dbg_ack  = (state == ACK) && owner_dbg;
    o_busy     = (state != IDLE);
  end

  // Request latch, latency counter, read capture and contention counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      owner_dbg   <= 1'b0;
      last_dbg    <= 1'b1;
      we_q        <= 1'b0;
      lat_cnt     <= 2'd0;
      o_mem_addr  <= '0;
      o_mem_wdat  <= 8'h00;
      o_core_rdat <= 8'h00;
      o_dbg_rdat  <= 8'h00;
      o_core_wait <= '0;
    end else begin
      if (grant_core || grant_dbg) begin
        owner_dbg  <= grant_dbg;
        last_dbg   <= grant_dbg;
        we_q       <= grant_dbg ? i_dbg_we   : i_core_we;
        o_mem_addr <= grant_dbg ? i_dbg_addr : i_core_addr;
        o_mem_wdat <= grant_dbg ? i_dbg_wdat : i_core_wdat;
      end
      if (state == ACCESS) lat_cnt <= lat_done ? 2'd0 : lat_cnt + 2'd1;
      if (state == ACCESS && lat_done && !we_q) begin
        if (owner_dbg) o_dbg_rdat  <= i_mem_rdat;
        else           o_core_rdat <= i_mem_rdat;
      end
      if (i_core_req && !core_served) o_core_wait <= sat_inc(o_core_wait);
    end
  end

endmodule

// File: tb/tb_oc8051_ice_xmem_arb.sv
// Bench for oc8051_ice_xmem_arb: one instance with MEM_LAT=1 and one with MEM_LAT=3, each checked
// every cycle against a timestamp-based transaction model, plus directed scenario checks.
module tb_oc8051_ice_xmem_arb;

  logic        clk = 1'b0;
  logic        rst      [2];
  logic        core_req [2];
  logic        core_we  [2];
  logic [15:0] core_addr[2];
  logic [7:0]  core_wdat[2];
  logic        core_ack [2];
  logic [7:0]  core_rdat[2];
  logic        dbg_req  [2];
  logic        dbg_we   [2];
  logic [15:0] dbg_addr [2];
  logic [7:0]  dbg_wdat [2];
  logic        dbg_ack  [2];
  logic [7:0]  dbg_rdat [2];
  logic        lock     [2];
  logic        mem_en   [2];
  logic        mem_we   [2];
  logic [15:0] mem_addr [2];
  logic [7:0]  mem_wdat [2];
  logic [7:0]  mem_rdat [2];
  logic        busy     [2];
  logic [15:0] core_wait[2];

  int errors = 0;
  int checks = 0;
  int t = 0;

  always #5 clk = ~clk;

  oc8051_ice_xmem_arb #(.AW(16), .MEM_LAT(1), .CW(16)) u_lat1 (
    .i_clk(clk), .i_rst(rst[0]),
    .i_core_req(core_req[0]), .i_core_we(core_we[0]), .i_core_addr(core_addr[0]),
    .i_core_wdat(core_wdat[0]), .o_core_ack(core_ack[0]), .o_core_rdat(core_rdat[0]),
    .i_dbg_req(dbg_req[0]), .i_dbg_we(dbg_we[0]), .i_dbg_addr(dbg_addr[0]),
    .i_dbg_wdat(dbg_wdat[0]), .o_dbg_ack(dbg_ack[0]), .o_dbg_rdat(dbg_rdat[0]),
    .i_dbg_lock(lock[0]), .o_mem_en(mem_en[0]), .o_mem_we(mem_we[0]),
    .o_mem_addr(mem_addr[0]), .o_mem_wdat(mem_wdat[0]), .i_mem_rdat(mem_rdat[0]),
    .o_busy(busy[0]), .o_core_wait(core_wait[0])
  );

  oc8051_ice_xmem_arb #(.AW(16), .MEM_LAT(3), .CW(16)) u_lat3 (
    .i_clk(clk), .i_rst(rst[1]),
    .i_core_req(core_req[1]), .i_core_we(core_we[1]), .i_core_addr(core_addr[1]),
    .i_core_wdat(core_wdat[1]), .o_core_ack(core_ack[1]), .o_core_rdat(core_rdat[1]),
    .i_dbg_req(dbg_req[1]), .i_dbg_we(dbg_we[1]), .i_dbg_addr(dbg_addr[1]),
    .i_dbg_wdat(dbg_wdat[1]), .o_dbg_ack(dbg_ack[1]), .o_dbg_rdat(dbg_rdat[1]),
    .i_dbg_lock(lock[1]), .o_mem_en(mem_en[1]), .o_mem_we(mem_we[1]),
    .o_mem_addr(mem_addr[1]), .o_mem_wdat(mem_wdat[1]), .i_mem_rdat(mem_rdat[1]),
    .o_busy(busy[1]), .o_core_wait(core_wait[1])
  );

  // 16-byte RAM per instance; read data is garbage except on the last enable cycle.
  logic       ram_clr = 1'b1;
  logic [7:0] ram [2][16];
  int         en_run [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ram_clr) begin
        for (int a = 0; a < 16; a++) ram[k][a] <= 8'h00;
      end else if (mem_en[k] === 1'b1 && mem_we[k] === 1'b1) begin
        ram[k][mem_addr[k][3:0]] <= mem_wdat[k];
      end
      en_run[k] <= (mem_en[k] === 1'b1) ? en_run[k] + 1 : 0;
    end
  end

  assign mem_rdat[0] = ram[0][mem_addr[0][3:0]] ^ ((en_run[0] == 0) ? 8'h00 : 8'hFF);
  assign mem_rdat[1] = ram[1][mem_addr[1][3:0]] ^ ((en_run[1] == 2) ? 8'h00 : 8'hFF);

  // Reference model state: a transaction granted at cycle g uses the RAM in cycles g+1..g+L and
  // acks in cycle g+L+1; the arbiter is free again from cycle g+L+2.
  bit          m_act  [2];
  int          m_g    [2];
  bit          m_own  [2];
  bit          m_we   [2];
  logic [15:0] m_addr [2];
  logic [7:0]  m_wdat [2];
  bit          m_lastd[2];
  int          m_wait [2];
  logic [7:0]  m_crd  [2];
  logic [7:0]  m_drd  [2];
  logic [7:0]  m_mem  [2][16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_act[k]   = 1'b0;
    m_lastd[k] = 1'b1;
    m_wait[k]  = 0;
    m_crd[k]   = 8'h00;
    m_drd[k]   = 8'h00;
    m_addr[k]  = 16'h0000;
    m_wdat[k]  = 8'h00;
  endtask

  task automatic model_step(input int k);
    int   lat;
    logic e_en, e_ca, e_da;
    bit   gc, gd;
    lat = (k == 0) ? 1 : 3;
    if (m_act[k] && t > m_g[k] + lat + 1) m_act[k] = 1'b0;
    e_en = m_act[k] && t >= m_g[k] + 1 && t <= m_g[k] + lat;
    e_ca = m_act[k] && t == m_g[k] + lat + 1 && !m_own[k];
    e_da = m_act[k] && t == m_g[k] + lat + 1 && m_own[k];
    chk($sformatf("u%0d_mem_en", k), 32'(mem_en[k]), 32'(e_en));
    chk($sformatf("u%0d_core_ack", k), 32'(core_ack[k]), 32'(e_ca));
    chk($sformatf("u%0d_dbg_ack", k), 32'(dbg_ack[k]), 32'(e_da));
    chk($sformatf("u%0d_busy", k), 32'(busy[k]), 32'(m_act[k]));
    chk($sformatf("u%0d_mem_addr", k), 32'(mem_addr[k]), 32'(m_addr[k]));
    chk($sformatf("u%0d_mem_wdat", k), 32'(mem_wdat[k]), 32'(m_wdat[k]));
    chk($sformatf("u%0d_core_wait", k), 32'(core_wait[k]), m_wait[k]);
    if (e_en) chk($sformatf("u%0d_mem_we", k), 32'(mem_we[k]), 32'(m_we[k]));
    if (e_ca) chk($sformatf("u%0d_core_rdat", k), 32'(core_rdat[k]), 32'(m_crd[k]));
    if (e_da) chk($sformatf("u%0d_dbg_rdat", k), 32'(dbg_rdat[k]), 32'(m_drd[k]));
    // The RAM itself is never reset, so its write lands even on a reset edge.
    if (e_en && m_we[k]) m_mem[k][m_addr[k][3:0]] = m_wdat[k];
    if (rst[k]) begin
      model_reset(k);
    end else begin
      if (core_req[k] && !(m_act[k] && !m_own[k] && t > m_g[k]) && m_wait[k] < 65535)
        m_wait[k]++;
      if (m_act[k] && !m_we[k] && t == m_g[k] + lat) begin
        if (m_own[k]) m_drd[k] = m_mem[k][m_addr[k][3:0]];
        else          m_crd[k] = m_mem[k][m_addr[k][3:0]];
      end
      if (!m_act[k]) begin
        gd = dbg_req[k] && (lock[k] || !core_req[k] || !m_lastd[k]);
        gc = core_req[k] && !lock[k] && (!dbg_req[k] || m_lastd[k]);
        if (gc || gd) begin
          m_act[k]   = 1'b1;
          m_g[k]     = t;
          m_own[k]   = gd;
          m_lastd[k] = gd;
          m_we[k]    = gd ? dbg_we[k]   : core_we[k];
          m_addr[k]  = gd ? dbg_addr[k] : core_addr[k];
          m_wdat[k]  = gd ? dbg_wdat[k] : core_wdat[k];
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step(0);
    model_step(1);
    @(posedge clk);
    t++;
    #1;
  endtask

  task automatic idle_inputs(input int k);
    core_req[k] = 1'b0; core_we[k] = 1'b0; core_addr[k] = 16'h0; core_wdat[k] = 8'h0;
    dbg_req[k]  = 1'b0; dbg_we[k]  = 1'b0; dbg_addr[k]  = 16'h0; dbg_wdat[k]  = 8'h0;
    lock[k]     = 1'b0;
  endtask

  initial begin
    int   q[$];
    int   cnt_c, cnt_d, dpre, ack_at, ncnt, w0;
    bit   seen;
    logic [7:0] rd;

    for (int k = 0; k < 2; k++) begin
      idle_inputs(k);
      rst[k] = 1'b1;
      model_reset(k);
      for (int a = 0; a < 16; a++) m_mem[k][a] = 8'h00;
    end
    @(posedge clk); #1; t = 1;
    cycle();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_busy%0d", k), 32'(busy[k]), 0);
      chk($sformatf("rst_en%0d", k), 32'(mem_en[k]), 0);
      chk($sformatf("rst_wait%0d", k), 32'(core_wait[k]), 0);
      chk($sformatf("rst_crdat%0d", k), 32'(core_rdat[k]), 0);
      rst[k] = 1'b0;
    end
    ram_clr = 1'b0;
    cycle();

    // Core write then debug read-back, MEM_LAT=1.
    core_we[0] = 1'b1; core_addr[0] = 16'h1234; core_wdat[0] = 8'hA5; core_req[0] = 1'b1;
    cycle();
    chk("t1_en", 32'(mem_en[0]), 1);
    chk("t1_we", 32'(mem_we[0]), 1);
    chk("t1_addr", 32'(mem_addr[0]), 32'h1234);
    chk("t1_noack", 32'(core_ack[0]), 0);
    cycle();
    chk("t1_ack", 32'(core_ack[0]), 1);
    chk("t1_en_off", 32'(mem_en[0]), 0);
    core_req[0] = 1'b0;
    cycle();
    dbg_we[0] = 1'b0; dbg_addr[0] = 16'h1234; dbg_req[0] = 1'b1;
    cycle();
    cycle();
    chk("t1_dack", 32'(dbg_ack[0]), 1);
    chk("t1_drdat", 32'(dbg_rdat[0]), 32'hA5);
    dbg_req[0] = 1'b0;
    cycle();

    // Simultaneous requests after reset alternate starting with the core.
    rst[0] = 1'b1; cycle(); rst[0] = 1'b0;
    core_we[0] = 1'b0; core_addr[0] = 16'h1231; core_req[0] = 1'b1;
    dbg_we[0]  = 1'b0; dbg_addr[0]  = 16'h1232; dbg_req[0]  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (core_ack[0] === 1'b1) q.push_back(0);
      if (dbg_ack[0] === 1'b1) q.push_back(1);
    end
    chk("t2_nacks", q.size(), 4);
    for (int i = 0; i < q.size() && i < 4; i++) chk($sformatf("t2_order%0d", i), q[i], i % 2);
    core_req[0] = 1'b0; dbg_req[0] = 1'b0;
    repeat (3) cycle();

    // Debug lock starves the core; releasing it lets the core in.
    w0 = int'(core_wait[0]);
    lock[0] = 1'b1; core_req[0] = 1'b1; dbg_req[0] = 1'b1;
    cnt_c = 0; cnt_d = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (core_ack[0] === 1'b1) cnt_c++;
      if (dbg_ack[0] === 1'b1) cnt_d++;
    end
    chk("t3_core_acks", cnt_c, 0);
    chk("t3_dbg_acks_ge6", 32'(cnt_d >= 6), 1);
    chk("t3_wait", 32'(core_wait[0]), w0 + 20);
    lock[0] = 1'b0;
    dpre = 0; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      if (core_ack[0] === 1'b1) seen = 1'b1;
      else if (dbg_ack[0] === 1'b1) dpre++;
    end
    chk("t3_core_after_unlock", 32'(seen), 1);
    chk("t3_dbg_before_core_le1", 32'(dpre <= 1), 1);
    core_req[0] = 1'b0; dbg_req[0] = 1'b0;
    repeat (4) cycle();

    // MEM_LAT=3: debug write, then core read sees exactly three enable cycles.
    dbg_we[1] = 1'b1; dbg_addr[1] = 16'h1237; dbg_wdat[1] = 8'h3C; dbg_req[1] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      if (dbg_ack[1] === 1'b1) seen = 1'b1;
    end
    chk("t4_wr_ack", 32'(seen), 1);
    dbg_req[1] = 1'b0;
    cycle();
    core_we[1] = 1'b0; core_addr[1] = 16'h1237; core_req[1] = 1'b1;
    ncnt = 0; ack_at = 0; rd = 8'h00;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      if (mem_en[1] === 1'b1) ncnt++;
      if (core_ack[1] === 1'b1 && ack_at == 0) begin
        ack_at = i; rd = core_rdat[1]; core_req[1] = 1'b0;
      end
    end
    chk("t4_en_cycles", ncnt, 3);
    chk("t4_ack_at", ack_at, 4);
    chk("t4_rdat", 32'(rd), 32'h3C);
    core_req[1] = 1'b0;
    cycle();

    // Reset during the second access cycle aborts without an ack.
    core_we[1] = 1'b0; core_addr[1] = 16'h1237; core_req[1] = 1'b1;
    cycle();
    cycle();
    chk("t5_in_access", 32'(mem_en[1]), 1);
    rst[1] = 1'b1; core_req[1] = 1'b0;
    cycle();
    rst[1] = 1'b0;
    chk("t5_en", 32'(mem_en[1]), 0);
    chk("t5_busy", 32'(busy[1]), 0);
    chk("t5_wait", 32'(core_wait[1]), 0);
    chk("t5_ack", 32'(core_ack[1]), 0);
    cnt_c = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (core_ack[1] === 1'b1) cnt_c++;
    end
    chk("t5_no_late_ack", cnt_c, 0);

    // Contention counter saturation under lock.
    rst[0] = 1'b1; cycle(); rst[0] = 1'b0;
    lock[0] = 1'b1; core_req[0] = 1'b1; dbg_req[0] = 1'b0;
    repeat (65536 + 5) cycle();
    chk("t6_sat", 32'(core_wait[0]), 32'hFFFF);
    idle_inputs(0);
    cycle();

    // Randomised traffic on both instances, protocol-free.
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 2; k++) begin
        core_req[k]  = ($urandom % 3) != 0;
        core_we[k]   = $urandom % 2;
        core_addr[k] = (($urandom % 8) == 0) ? 16'($urandom) : {12'h123, 4'($urandom)};
        core_wdat[k] = 8'($urandom);
        dbg_req[k]   = ($urandom % 3) != 0;
        dbg_we[k]    = $urandom % 2;
        dbg_addr[k]  = (($urandom % 8) == 0) ? 16'($urandom) : {12'h123, 4'($urandom)};
        dbg_wdat[k]  = 8'($urandom);
        if (($urandom % 16) == 0) lock[k] = ~lock[k];
        rst[k]       = ($urandom % 250) == 0;
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
